io_arbiter: RTL and testbench

Shares the io_filter output ports between several CPU cores. Each core presents one message at a time (target port index plus data byte) on a valid/ready handshake. The arbiter grants at most one message per cycle in round-robin order and emits it as a single-cycle `port_active_out` pulse with data on the matching lane. It sits between the cores' I/O request logic and the io_filter `port_active_out`/`port_data_out` inputs. It also discards messages addressed to ports that cannot accept output, and counts them.

---
 rtl/io_pkg.sv | 15 +
 rtl/io_arbiter_rr_picker.sv | 40 ++++
 rtl/io_arbiter.sv | 149 ++++++++++++++
 tb/tb_io_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Constants shared by io_arbiter and the io_filter benches.
package io_pkg;

  localparam int unsigned IO_PINS = 4;

  // Width of a port index covering pins 0..io_pins-1 plus the two extra ports.
  function automatic int unsigned port_bits_for(input int unsigned io_pins);
    return $clog2(io_pins + 2);
  endfunction

  localparam int unsigned PORT_BITS      = port_bits_for(IO_PINS);
  localparam int unsigned EXTRA_OUT_PORT = IO_PINS;
  localparam int unsigned EXTRA_IN_PORT  = IO_PINS + 1;

endpackage

// File: rtl/io_arbiter_rr_picker.sv
// Combinational masked round-robin select: first eligible requester at or
// after ptr, wrapping to the lowest eligible requester below ptr.
module rr_picker #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             grant_any
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] masked;
  logic [N-1:0] cand;
  logic         found;

  // Prefer requesters at/above the pointer; fall back to the full vector.
  always_comb begin
    upper_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      upper_mask[i] = (IDX_W'(i) >= ptr);
    end
    masked    = eligible & upper_mask;
    cand      = (|masked) ? masked : eligible;
    grant     = '0;
    idx       = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cand[i] && !found) begin
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
        found    = 1'b1;
      end
    end
    grant_any = |eligible;
  end

endmodule

// File: rtl/io_arbiter.sv
// Round-robin arbiter sharing the io_filter output ports between cores.
// Illegal-port messages are accepted, dropped and counted.
module io_arbiter #(
  parameter  int unsigned CORES      = 4,
  parameter  int unsigned IO_PINS    = 4,
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned GAP        = 2,
  parameter  int unsigned ERR_WIDTH  = 8,
  localparam int unsigned PORT_BITS  = io_pkg::port_bits_for(IO_PINS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CORES-1:0]                 req_valid,
  output logic [CORES-1:0]                 req_ready,
  input  logic [CORES*PORT_BITS-1:0]       req_port,
  input  logic [CORES*DATA_WIDTH-1:0]      req_data,
  input  logic [IO_PINS-1:0]               pin_dir,
  output logic [IO_PINS+1:0]               port_active_out,
  output logic [(IO_PINS+2)*DATA_WIDTH-1:0] port_data_out,
  output logic [ERR_WIDTH-1:0]             err_count,
  input  logic                             err_clear
);

  localparam int unsigned NPORTS = IO_PINS + 2;
  localparam int unsigned IDX_W  = (CORES > 1) ? $clog2(CORES) : 1;
  localparam int unsigned CNT_W  = (GAP > 0) ? $clog2(GAP + 1) : 1;

  logic [NPORTS-1:0][CNT_W-1:0] holdoff;
  logic [NPORTS-1:0]            port_busy;
  logic [CORES-1:0]             eligible;
  logic [CORES-1:0]             grant;
  logic [IDX_W-1:0]             ptr;
  logic [IDX_W-1:0]             win_idx;
  logic                         grant_any;
  logic                         transfer;
  logic [PORT_BITS-1:0]         win_port;
  logic [DATA_WIDTH-1:0]        win_data;
  logic                         win_legal;

  function automatic logic port_legal(input logic [PORT_BITS-1:0] p,
                                      input logic [IO_PINS-1:0]   dir);
    logic legal;
    legal = (p == PORT_BITS'(IO_PINS));
    for (int unsigned i = 0; i < IO_PINS; i++) begin
      if (p == PORT_BITS'(i)) legal = dir[i];
    end
    return legal;
  endfunction

  function automatic logic port_is_busy(input logic [PORT_BITS-1:0] p,
                                        input logic [NPORTS-1:0]    busy);
    logic b;
    b = 1'b0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (p == PORT_BITS'(i)) b = busy[i];
    end
    return b;
  endfunction

  // A core may compete if its port is idle; illegal ports never block.
  always_comb begin
    port_busy = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      port_busy[i] = (holdoff[i] != '0);
    end
    eligible = '0;
    for (int unsigned c = 0; c < CORES; c++) begin
      eligible[c] = req_valid[c] &&
        (!port_legal(req_port[c*PORT_BITS +: PORT_BITS], pin_dir) ||
         !port_is_busy(req_port[c*PORT_BITS +: PORT_BITS], port_busy));
    end
  end

  rr_picker #(.N(CORES)) u_picker (
    .eligible  (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .idx       (win_idx),
    .grant_any (grant_any)
  );

  // Route the winner's message and decide whether it is issued or dropped.
  always_comb begin
    win_port = '0;
    win_data = '0;
    for (int unsigned c = 0; c < CORES; c++) begin
      if (grant[c]) begin
        win_port = req_port[c*PORT_BITS +: PORT_BITS];
        win_data = req_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    win_legal = port_legal(win_port, pin_dir);
    transfer  = rst_n && grant_any;
    req_ready = rst_n ? grant : '0;
  end

  // Per-port holdoff: load GAP on issue, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      holdoff <= '0;
    end else begin
      for (int unsigned i = 0; i < NPORTS; i++) begin
        if (transfer && win_legal && (win_port == PORT_BITS'(i))) begin
          holdoff[i] <= CNT_W'(GAP);
        end else if (holdoff[i] != '0) begin
          holdoff[i] <= holdoff[i] - 1'b1;
        end
      end
    end
  end

  // One-cycle issue strobe and data lane for a legal transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      port_active_out <= '0;
      port_data_out   <= '0;
    end else begin
      port_active_out <= '0;
      port_data_out   <= '0;
      for (int unsigned i = 0; i < NPORTS; i++) begin
        if (transfer && win_legal && (win_port == PORT_BITS'(i))) begin
          port_active_out[i]                        <= 1'b1;
          port_data_out[i*DATA_WIDTH +: DATA_WIDTH] <= win_data;
        end
      end
    end
  end

  // Round-robin pointer advances past the winner on any transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= (win_idx == IDX_W'(CORES - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Saturating discard counter; clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clear) begin
      err_count <= '0;
    end else if (transfer && !win_legal && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_io_arbiter.sv
// Bench for io_arbiter: directed vector table, hand sequences and a random
// phase, all checked against a cycle-level model of the arbitration rules.
module tb_io_arbiter;

  localparam int CORES = 4;
  localparam int IO_PINS = 4;
  localparam int DW = 8;
  localparam int GAP = 2;
  localparam int EW = 8;
  localparam int NP = IO_PINS + 2;
  localparam int PB = 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [CORES-1:0]     req_valid = '0;
  logic [CORES-1:0]     req_ready;
  logic [CORES*PB-1:0]  req_port = '0;
  logic [CORES*DW-1:0]  req_data = '0;
  logic [IO_PINS-1:0]   pin_dir = 4'b0101;
  logic [NP-1:0]        port_active_out;
  logic [NP*DW-1:0]     port_data_out;
  logic [EW-1:0]        err_count;
  logic                 err_clear = 1'b0;

  io_arbiter #(
    .CORES(CORES), .IO_PINS(IO_PINS), .DATA_WIDTH(DW), .GAP(GAP), .ERR_WIDTH(EW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_port(req_port), .req_data(req_data), .pin_dir(pin_dir),
    .port_active_out(port_active_out), .port_data_out(port_data_out),
    .err_count(err_count), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: absolute cycle at which each port is next free.
  int          m_cycle = 0;
  int          m_free[8];
  int          m_ptr = 0;
  int          m_err = 0;
  logic [NP-1:0]    m_act = '0;
  logic [NP*DW-1:0] m_data = '0;
  logic [CORES-1:0] m_ready;
  int          m_win;
  int          m_win_port;
  logic [7:0]  m_win_data;
  bit          m_win_legal;

  typedef struct {
    logic [3:0]  valid;
    logic [11:0] port;
    logic [31:0] data;
    logic        clr;
    logic [3:0]  exp_ready;
    logic [5:0]  exp_act;
    logic [7:0]  exp_err;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cycle);
    end
  endtask

  function automatic bit legal(input int p, input logic [3:0] dir);
    if (p < IO_PINS) return dir[p];
    return p == IO_PINS;
  endfunction

  function automatic logic [11:0] pk(input int p3, input int p2, input int p1, input int p0);
    return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
  endfunction

  task automatic model_comb();
    m_ready = '0;
    m_win = -1;
    if (rst_n) begin
      for (int k = 0; k < CORES; k++) begin
        int c;
        int p;
        c = (m_ptr + k) % CORES;
        p = int'(req_port[c*PB +: PB]);
        if (m_win < 0 && req_valid[c] && (!legal(p, pin_dir) || m_cycle >= m_free[p])) begin
          m_win = c;
          m_win_port = p;
          m_win_data = req_data[c*DW +: DW];
          m_win_legal = legal(p, pin_dir);
        end
      end
      if (m_win >= 0) m_ready[m_win] = 1'b1;
    end
  endtask

  task automatic model_seq();
    if (!rst_n) begin
      m_act = '0;
      m_data = '0;
      m_err = 0;
      m_ptr = 0;
      for (int i = 0; i < 8; i++) m_free[i] = 0;
    end else begin
      m_act = '0;
      m_data = '0;
      if (m_win >= 0) begin
        if (m_win_legal) begin
          m_act[m_win_port] = 1'b1;
          m_data[m_win_port*DW +: DW] = m_win_data;
          m_free[m_win_port] = m_cycle + GAP + 1;
        end else if (m_err < 255) begin
          m_err++;
        end
        m_ptr = (m_win + 1) % CORES;
      end
      if (err_clear) m_err = 0;
    end
    m_cycle++;
  endtask

  // One clock: sample mid-cycle, compare against the model, advance it.
  task automatic step(output logic [3:0] rdy, output logic [5:0] act, output logic [7:0] err);
    @(negedge clk);
    model_comb();
    rdy = req_ready;
    act = port_active_out;
    err = err_count;
    chk("req_ready", 64'(req_ready), 64'(m_ready));
    chk("port_active_out", 64'(port_active_out), 64'(m_act));
    chk("port_data_out", 64'(port_data_out), 64'(m_data));
    chk("err_count", 64'(err_count), 64'(m_err));
    model_seq();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] v, input logic [11:0] p, input logic [31:0] d,
                     input logic c, input logic [3:0] r, input logic [5:0] a, input logic [7:0] e);
    vec_t t;
    t.valid = v; t.port = p; t.data = d; t.clr = c;
    t.exp_ready = r; t.exp_act = a; t.exp_err = e;
    tbl.push_back(t);
  endtask

  initial begin
    logic [3:0] rdy;
    logic [5:0] act;
    logic [7:0] err;
    for (int i = 0; i < 8; i++) m_free[i] = 0;

    // Directed table from a fresh reset, pin_dir = 0101, one row per cycle.
    add(4'b0010, pk(0,0,2,0), 32'h0000FF00, 0, 4'b0010, 6'b000000, 0); // single issue
    add(4'b0000, pk(0,0,0,0), 32'h0,        0, 4'b0000, 6'b000100, 0);
    add(4'b1001, pk(4,0,0,0), 32'hC3000011, 0, 4'b1000, 6'b000000, 0); // ptr=2: core3 first
    add(4'b0001, pk(0,0,0,0), 32'h00000011, 0, 4'b0001, 6'b010000, 0); // then core0
    add(4'b0000, pk(0,0,0,0), 32'h0,        0, 4'b0000, 6'b000001, 0);
    add(4'b0000, pk(0,0,0,0), 32'h0,        0, 4'b0000, 6'b000000, 0);
    add(4'b0011, pk(0,0,2,2), 32'h00002211, 0, 4'b0010, 6'b000000, 0); // ptr ended at 1
    add(4'b1000, pk(5,0,0,0), 32'h77000000, 0, 4'b1000, 6'b000100, 0); // illegal, ptr->0
    add(4'b0101, pk(0,4,0,0), 32'h00B200A1, 0, 4'b0001, 6'b000000, 1); // holdoff sequence
    add(4'b0101, pk(0,4,0,0), 32'h00B200A2, 0, 4'b0100, 6'b000001, 1);
    add(4'b0001, pk(0,0,0,0), 32'h000000A2, 0, 4'b0000, 6'b010000, 1);
    add(4'b0001, pk(0,0,0,0), 32'h000000A2, 0, 4'b0001, 6'b000000, 1);
    add(4'b0000, pk(0,0,0,0), 32'h0,        1, 4'b0000, 6'b000001, 1);
    add(4'b0100, pk(0,3,0,0), 32'h00330000, 0, 4'b0100, 6'b000000, 0); // discard pin 3
    add(4'b0100, pk(0,5,0,0), 32'h00550000, 0, 4'b0100, 6'b000000, 1); // discard port 5
    add(4'b0100, pk(0,5,0,0), 32'h00550000, 1, 4'b0100, 6'b000000, 2); // clear + illegal
    add(4'b0000, pk(0,0,0,0), 32'h0,        0, 4'b0000, 6'b000000, 0);

    // Reset held with every core requesting.
    rst_n = 1'b0;
    req_valid = 4'b1111;
    req_port = pk(4,2,0,4);
    for (int i = 0; i < 4; i++) begin
      step(rdy, act, err);
      chk("reset_ready", 64'(rdy), 64'h0);
    end
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      req_valid = tbl[i].valid;
      req_port = tbl[i].port;
      req_data = tbl[i].data;
      err_clear = tbl[i].clr;
      step(rdy, act, err);
      chk($sformatf("tbl%0d_ready", i), 64'(rdy), 64'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_act", i), 64'(act), 64'(tbl[i].exp_act));
      chk($sformatf("tbl%0d_err", i), 64'(err), 64'(tbl[i].exp_err));
    end
    err_clear = 1'b0;

    // Saturation of the discard counter.
    req_valid = 4'b0010;
    req_port = pk(0,0,7,0);
    for (int i = 0; i < 300; i++) step(rdy, act, err);
    req_valid = '0;
    step(rdy, act, err);
    chk("err_saturate", 64'(err), 64'd255);

    // Reset right after an issue to port 2.
    req_valid = 4'b0010;
    req_port = pk(0,0,2,0);
    req_data = 32'h00005A00;
    step(rdy, act, err);
    chk("midrst_issue_ready", 64'(rdy), 64'b0010);
    req_valid = '0;
    rst_n = 1'b0;
    step(rdy, act, err);
    rst_n = 1'b1;
    req_valid = 4'b1010;
    req_port = pk(4,0,2,0);
    req_data = 32'h99006600;
    step(rdy, act, err);
    chk("midrst_nostrobe", 64'(act), 64'h0);
    chk("midrst_regrant", 64'(rdy), 64'b0010);
    req_valid = '0;
    step(rdy, act, err);
    chk("midrst_strobe", 64'(act), 64'b000100);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      req_valid = 4'($urandom);
      req_port = 12'($urandom);
      req_data = $urandom;
      if ($urandom_range(7) == 0) pin_dir = 4'($urandom);
      err_clear = ($urandom_range(31) == 0);
      rst_n = ($urandom_range(63) != 0);
      step(rdy, act, err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
